// File: rtl/mod_counter_if.sv
// mod_counter_if: control, compare and status signals of the modulo counter
interface mod_counter_if #(
    parameter int BITS = 8
);
    logic            i_clr;
    logic            i_load;
    logic [BITS-1:0] i_load_val;
    logic            i_en;
    logic            i_dir;
    logic            i_sat;
    logic [BITS-1:0] i_cmp_val;
    logic            i_ovf_clr;
    logic [BITS-1:0] o_count;
    logic            o_tc;
    logic            o_cmp;
    logic            o_ovf;

    modport master (
        output i_clr, i_load, i_load_val, i_en, i_dir, i_sat, i_cmp_val, i_ovf_clr,
        input  o_count, o_tc, o_cmp, o_ovf
    );

    modport slave (
        input  i_clr, i_load, i_load_val, i_en, i_dir, i_sat, i_cmp_val, i_ovf_clr,
        output o_count, o_tc, o_cmp, o_ovf
    );
endinterface

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with wrap/saturate, terminal-count, compare and sticky overflow
module mod_counter #(
    parameter int BITS    = 8,
    parameter int MOD_MAX = 2**BITS-1
) (
    input logic         i_clk,
    input logic         i_rst_n,
    mod_counter_if.slave bus
);
    localparam logic [BITS-1:0] MAX = BITS'(MOD_MAX);

    logic [BITS-1:0] count_q, count_d, load_cl, step;
    logic            tc_q, tc_d, cmp_q, cmp_d, ovf_q, ovf_d;
    logic            at_lim, wr;

    always_comb begin
        at_lim  = bus.i_dir ? (count_q == MAX) : (count_q == '0);
        load_cl = (bus.i_load_val > MAX) ? MAX : bus.i_load_val;
        step    = bus.i_dir ? count_q + BITS'(1) : count_q - BITS'(1);
        // limit steps wrap or hold so the count never leaves 0..MAX
        count_d = bus.i_clr  ? '0 :
                  bus.i_load ? load_cl :
                  !bus.i_en  ? count_q :
                  !at_lim    ? step :
                  bus.i_sat  ? count_q :
                  bus.i_dir  ? '0 : MAX;
        wr      = bus.i_clr | bus.i_load | (bus.i_en & !(at_lim & bus.i_sat));
        tc_d    = !bus.i_clr & !bus.i_load & bus.i_en & at_lim;
        ovf_d   = bus.i_clr ? 1'b0 : tc_d ? 1'b1 : bus.i_ovf_clr ? 1'b0 : ovf_q;
        cmp_d   = wr & (count_d == bus.i_cmp_val);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            cmp_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            cmp_q   <= cmp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.o_count = count_q;
    assign bus.o_tc    = tc_q;
    assign bus.o_cmp   = cmp_q;
    assign bus.o_ovf   = ovf_q;
endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
- REQ-001: Parameter BITS, default 8; width of count, load and compare values.
- REQ-002: Parameter MOD_MAX, default 2**BITS-1; terminal count value; legal range 1..2**BITS-1.
- REQ-003: i_clk  input  1  sole clock; all state updates on rising edge.
- REQ-004: i_rst_n  input  1  reset, synchronous, active-low.
- REQ-005: i_clr  input  1  synchronous clear of count and overflow flag.
- REQ-006: i_load  input  1  load i_load_val into count.
- REQ-007: i_load_val  input  BITS  load value.
- REQ-008: i_en  input  1  count enable; one step per enabled cycle.
- REQ-009: i_dir  input  1  count direction; 1 = up, 0 = down.
- REQ-010: i_sat  input  1  limit mode; 1 = saturate at limits, 0 = wrap modulo MOD_MAX+1.
- REQ-011: i_cmp_val  input  BITS  compare value.
- REQ-012: i_ovf_clr  input  1  clear sticky overflow flag.
- REQ-013: o_count  output  BITS  registered count, range 0..MOD_MAX.
- REQ-014: o_tc  output  1  registered one-cycle terminal-count pulse.
- REQ-015: o_cmp  output  1  registered one-cycle compare-match pulse.
- REQ-016: o_ovf  output  1  registered sticky overflow/underflow flag.

Function
- REQ-017: Control priority per edge: reset first, then i_clr, then i_load, then i_en, otherwise hold.
- REQ-018: i_clr sets o_count to 0 and o_ovf to 0; o_tc = 0 on the following cycle.
- REQ-019: i_load sets o_count to i_load_val; values above MOD_MAX are clamped to MOD_MAX; o_tc = 0; o_ovf unchanged.
- REQ-020: i_en with i_dir=1 and o_count<MOD_MAX increments o_count by 1.
- REQ-021: i_en with i_dir=0 and o_count>0 decrements o_count by 1.
- REQ-022: Limit event: i_en with (i_dir=1 and o_count=MOD_MAX) or (i_dir=0 and o_count=0).
- REQ-023: On a limit event with i_sat=0, o_count wraps: up goes to 0, down goes to MOD_MAX.
- REQ-024: On a limit event with i_sat=1, o_count holds its value.
- REQ-025: Every limit event, in either mode, asserts o_tc for exactly the one cycle following the edge and sets o_ovf on the same edge.
- REQ-026: Limit events on consecutive enabled cycles (saturated hold) produce o_tc high on each such cycle.
- REQ-027: o_ovf stays 1 until i_clr, i_ovf_clr or reset.
- REQ-028: If i_ovf_clr and a limit event occur on the same edge, o_ovf = 1 (set wins).
- REQ-029: o_cmp = 1 for the one cycle after an edge on which o_count was written (clear, load, step or wrap) with a new value equal to i_cmp_val, sampled on that edge.
- REQ-030: A saturated hold and an idle hold are not writes; they produce no o_cmp pulse.
- REQ-031: i_dir, i_sat and i_cmp_val may change on any cycle and take effect on the next edge.
- REQ-032: Latency: o_count, o_tc, o_cmp and o_ovf all update on the same edge that samples the controls.
- REQ-033: All count arithmetic is BITS wide; no intermediate value may leave the range 0..MOD_MAX.

Reset
- REQ-034: While i_rst_n=0 at an edge: o_count=0, o_tc=0, o_cmp=0, o_ovf=0, regardless of other inputs.
- REQ-035: Reset asserted mid-count discards all state; counting resumes from 0 on the first edge after release with i_en=1.
- REQ-036: o_cmp does not pulse on reset, even when i_cmp_val=0.

Verification (BITS=4, MOD_MAX=9)
- REQ-037: Wrap up: load 8, i_dir=1, i_sat=0, i_en=1 for 3 cycles -> o_count 9,0,1; o_tc high only in the cycle showing 0; o_ovf=1 from then on.
- REQ-038: Saturate down: load 1, i_dir=0, i_sat=1, i_en=1 for 3 cycles -> o_count 0,0,0; o_tc high in the 2nd and 3rd cycles; o_ovf=1.
- REQ-039: Clamp and compare: i_cmp_val=9, load 14 -> o_count=9, o_cmp pulses 1 cycle; then hold i_en=0 for 2 cycles -> no further o_cmp.
- REQ-040: Priority: i_clr=1, i_load=1 (val 5), i_en=1 on the same edge -> o_count=0, o_ovf=0; next edge with i_load=1, i_en=1 -> o_count=5.
- REQ-041: Set-wins: o_ovf=1 and count=9 up with wrap, i_ovf_clr=1 on that edge -> o_count=0, o_ovf stays 1; i_ovf_clr alone next edge -> o_ovf=0.
- REQ-042: Reset mid-count: count at 6, i_rst_n=0 for 1 edge with i_en=1 -> all outputs 0; release -> o_count 1,2 on the next two edges.
